// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fetch_pkg
// Brief    : Shared widths, state encoding and buffer entry type for fetch.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : fetch_unit_if
// Brief     : Memory-side and decode-side signals of the fetch stage.
// Options   : FETCH_MISALIGN_TRAP_EN adds fetch_misaligned_o.
// Revision  : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    import fetch_pkg::*;

    logic [XLEN-1:0] imem_addr_o;
    logic [XLEN-1:0] imem_instr_i;
    logic            redirect_valid_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            fetch_valid_o;
    logic            fetch_ready_i;
    logic [XLEN-1:0] fetch_pc_o;
    logic [XLEN-1:0] fetch_instr_o;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            fetch_misaligned_o;
`endif

    modport master (
        output imem_addr_o,
        input  imem_instr_i,
        input  redirect_valid_i,
        input  redirect_pc_i,
        output fetch_valid_o,
        input  fetch_ready_i,
        output fetch_pc_o,
`ifdef FETCH_MISALIGN_TRAP_EN
        output fetch_misaligned_o,
`endif
        output fetch_instr_o
    );

    modport slave (
        input  imem_addr_o,
        output imem_instr_i,
        output redirect_valid_i,
        output redirect_pc_i,
        input  fetch_valid_o,
        output fetch_ready_i,
        input  fetch_pc_o,
`ifdef FETCH_MISALIGN_TRAP_EN
        input  fetch_misaligned_o,
`endif
        input  fetch_instr_o
    );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Synchronous FIFO with flush; head is read combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  wire                           clk,
    input  wire                           rst,
    input  wire                           i_flush,
    input  wire                           i_push,
    input  wire [WIDTH-1:0]               i_push_data,
    input  wire                           i_pop,
    output logic [WIDTH-1:0]              o_head_data,
    output logic                          o_empty,
    output logic [$clog2(DEPTH+1)-1:0]    o_count
);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_full;
    logic               w_push;
    logic               w_pop;

    assign o_empty     = (r_count == '0);
    assign w_full      = (r_count == c_CNT_W'(DEPTH));
    assign w_pop       = i_pop && !o_empty;
    // A push into a full buffer is accepted when the head leaves in the same cycle.
    assign w_push      = i_push && (!w_full || w_pop);
    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;

    always_ff @(posedge clk) begin
        if (w_push && !rst && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : PC owner, instruction-memory issue and buffered decode handoff.
// Options  : FETCH_MISALIGN_TRAP_EN enables misaligned-redirect trap and HALT.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  wire          clk_i,
    input  wire          reset_i,
    fetch_unit_if.master bus
);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_OCC_W = c_CNT_W + 1;

    fetch_state_t       r_state;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_inflight_pc;
    logic               r_inflight;

    logic               w_redirect;
    logic [XLEN-1:0]    w_redirect_pc;
    logic               w_empty;
    logic [c_CNT_W-1:0] w_count;
    logic [c_OCC_W-1:0] w_occupancy;
    logic               w_head_valid;
    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head_entry;

    assign w_redirect   = bus.redirect_valid_i;
    assign w_head_valid = !w_empty;
    assign w_valid      = w_head_valid && !w_redirect;
    assign w_pop        = w_valid && bus.fetch_ready_i;
    // A redirect kills the response arriving this cycle.
    assign w_push       = r_inflight && !w_redirect;
    assign w_push_entry = {r_inflight_pc, bus.imem_instr_i};

    // Slots committed after this edge; a new issue needs one left for its response.
    assign w_occupancy  = c_OCC_W'(w_count) + c_OCC_W'(r_inflight) - c_OCC_W'(w_pop);
    assign w_issue      = (r_state == RUN) && !w_redirect &&
                          (w_occupancy < c_OCC_W'(FIFO_DEPTH));

`ifdef FETCH_MISALIGN_TRAP_EN
    logic w_misaligned;
    logic r_misaligned;

    assign w_misaligned           = w_redirect && (bus.redirect_pc_i[1:0] != 2'b00);
    assign w_redirect_pc          = bus.redirect_pc_i;
    assign bus.fetch_misaligned_o = r_misaligned;
`else
    logic w_unused_low_bits;

    assign w_redirect_pc     = {bus.redirect_pc_i[XLEN-1:2], 2'b00};
    assign w_unused_low_bits = ^bus.redirect_pc_i[1:0];
`endif

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk_i),
        .rst         (reset_i),
        .i_flush     (w_redirect),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head_data (w_head_entry),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    assign bus.imem_addr_o   = {2'b00, r_pc[XLEN-1:2]};
    assign bus.fetch_valid_o = w_valid;
    assign bus.fetch_pc_o    = w_head_valid ? w_head_entry.pc    : '0;
    assign bus.fetch_instr_o = w_head_valid ? w_head_entry.instr : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_misaligned  <= 1'b0;
`endif
        end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
            r_misaligned <= w_misaligned;
`endif
            if (w_redirect) begin
                r_pc       <= w_redirect_pc;
                r_inflight <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                r_state    <= w_misaligned ? HALT : RUN;
`else
                r_state    <= RUN;
`endif
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_pc          <= r_pc + XLEN'(4);
                    r_inflight_pc <= r_pc;
                end
                case (r_state)
                    BOOT:    r_state <= RUN;
                    RUN:     r_state <= RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
                    HALT:    r_state <= HALT;
`endif
                    default: r_state <= BOOT;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit with an in-bench memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mem [0:255];

    fetch_unit_if fbus ();
    fetch_unit_if wbus ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (fbus)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (wbus)
    );

    always #5 clk = ~clk;

    // Instruction memory: one-cycle registered read of the presented word address.
    always @(posedge clk) begin
        fbus.imem_instr_i <= mem[fbus.imem_addr_o[7:0]];
        wbus.imem_instr_i <= mem[wbus.imem_addr_o[7:0]];
    end

    function automatic logic [31:0] instr_at(input logic [31:0] pc);
        return mem[pc[9:2]];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic ready);
        rst                   = 1'b1;
        fbus.redirect_valid_i = 1'b0;
        fbus.fetch_ready_i    = ready;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        n_cmp++;
        if (fbus.fetch_valid_o !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %0b want 0", fbus.fetch_valid_o);
        end
        n_cmp++;
        if (fbus.fetch_pc_o !== 32'h0 || fbus.fetch_instr_o !== 32'h0) begin
            n_err++; $display("FAIL reset_head: got pc %h instr %h want 0/0", fbus.fetch_pc_o, fbus.fetch_instr_o);
        end
        n_cmp++;
        if (fbus.imem_addr_o !== 32'h0) begin
            n_err++; $display("FAIL reset_addr: got %h want 00000000", fbus.imem_addr_o);
        end
        n_cmp++;
        if (wbus.imem_addr_o !== 32'h3FFF_FFFE) begin
            n_err++; $display("FAIL reset_addr_wrap: got %h want 3ffffffe", wbus.imem_addr_o);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        n_cmp++;
        if (fbus.fetch_misaligned_o !== 1'b0) begin
            n_err++; $display("FAIL reset_misaligned: got %0b want 0", fbus.fetch_misaligned_o);
        end
`endif
        step();
    endtask

    // Boot latency on the main instance plus pc wrap on the second instance.
    task automatic test_boot_and_wrap();
        logic [31:0] e_pc;
        apply_reset(1'b1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 4) begin
                n_cmp++;
                if (fbus.imem_addr_o !== 32'(c - 1)) begin
                    n_err++; $display("FAIL boot_addr C%0d: got %h want %h", c, fbus.imem_addr_o, 32'(c - 1));
                end
            end
            if (c < 3) begin
                n_cmp++;
                if (fbus.fetch_valid_o !== 1'b0 || wbus.fetch_valid_o !== 1'b0) begin
                    n_err++; $display("FAIL boot_early_valid C%0d: got %0b/%0b want 0/0", c, fbus.fetch_valid_o, wbus.fetch_valid_o);
                end
            end else begin
                if (c <= 4) begin
                    e_pc = 32'(4 * (c - 3));
                    n_cmp++;
                    if (fbus.fetch_valid_o !== 1'b1 || fbus.fetch_pc_o !== e_pc || fbus.fetch_instr_o !== instr_at(e_pc)) begin
                        n_err++; $display("FAIL boot_deliver C%0d: got v%0b pc %h instr %h want v1 pc %h instr %h",
                                          c, fbus.fetch_valid_o, fbus.fetch_pc_o, fbus.fetch_instr_o, e_pc, instr_at(e_pc));
                    end
                end
                e_pc = 32'hFFFF_FFF8 + 32'(4 * (c - 3));
                n_cmp++;
                if (wbus.fetch_valid_o !== 1'b1 || wbus.fetch_pc_o !== e_pc || wbus.fetch_instr_o !== instr_at(e_pc)) begin
                    n_err++; $display("FAIL wrap_deliver C%0d: got v%0b pc %h instr %h want v1 pc %h instr %h",
                                      c, wbus.fetch_valid_o, wbus.fetch_pc_o, wbus.fetch_instr_o, e_pc, instr_at(e_pc));
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        apply_reset(1'b0);
        step(); step(); step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (fbus.fetch_valid_o !== 1'b1 || fbus.fetch_pc_o !== 32'h0 || fbus.fetch_instr_o !== instr_at(32'h0)) begin
                n_err++; $display("FAIL bp_hold k%0d: got v%0b pc %h instr %h want v1 pc 0 instr %h",
                                  k, fbus.fetch_valid_o, fbus.fetch_pc_o, fbus.fetch_instr_o, instr_at(32'h0));
            end
            n_cmp++;
            if (fbus.imem_addr_o !== 32'h2) begin
                n_err++; $display("FAIL bp_addr_hold k%0d: got %h want 00000002", k, fbus.imem_addr_o);
            end
            step();
        end
        fbus.fetch_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (fbus.fetch_valid_o !== 1'b1 || fbus.fetch_pc_o !== 32'(4 * k) || fbus.fetch_instr_o !== instr_at(32'(4 * k))) begin
                n_err++; $display("FAIL bp_release k%0d: got v%0b pc %h want v1 pc %h", k, fbus.fetch_valid_o, fbus.fetch_pc_o, 32'(4 * k));
            end
            step();
        end
    endtask

    task automatic test_redirect();
        logic got;
        apply_reset(1'b0);
        step(); step(); step(); step();
        fbus.fetch_ready_i    = 1'b1;
        fbus.redirect_valid_i = 1'b1;
        fbus.redirect_pc_i    = 32'h40;
        @(negedge clk);
        n_cmp++;
        if (fbus.fetch_valid_o !== 1'b0) begin
            n_err++; $display("FAIL redir_valid_forced: got %0b want 0", fbus.fetch_valid_o);
        end
        step();
        fbus.redirect_valid_i = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge clk);
            if (fbus.fetch_valid_o) begin
                got = 1'b1;
                n_cmp++;
                if (fbus.fetch_pc_o !== 32'h40 || fbus.fetch_instr_o !== instr_at(32'h40)) begin
                    n_err++; $display("FAIL redir_target: got pc %h instr %h want pc 00000040 instr %h",
                                      fbus.fetch_pc_o, fbus.fetch_instr_o, instr_at(32'h40));
                end
            end
            step();
        end
        if (!got) begin
            n_cmp++; n_err++; $display("FAIL redir_timeout: got no valid want pc 00000040");
        end
        @(negedge clk);
        n_cmp++;
        if (fbus.fetch_valid_o !== 1'b1 || fbus.fetch_pc_o !== 32'h44) begin
            n_err++; $display("FAIL redir_follow: got v%0b pc %h want v1 pc 00000044", fbus.fetch_valid_o, fbus.fetch_pc_o);
        end
        step();
    endtask

    // Random ready/redirect traffic checked against an in-order expected-pc stream.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic        redir;
        apply_reset(1'b0);
        exp_pc = 32'h0;
        for (int i = 0; i < 600; i++) begin
            fbus.fetch_ready_i = ($urandom_range(0, 9) < 7);
            redir = ($urandom_range(0, 19) == 0);
            tgt   = $urandom;
            tgt   = tgt & 32'h0000_0FFF;
`ifdef FETCH_MISALIGN_TRAP_EN
            tgt[1:0] = 2'b00;
`endif
            fbus.redirect_valid_i = redir;
            fbus.redirect_pc_i    = tgt;
            @(negedge clk);
            if (redir) begin
                n_cmp++;
                if (fbus.fetch_valid_o !== 1'b0) begin
                    n_err++; $display("FAIL rand_redir_valid i%0d: got %0b want 0", i, fbus.fetch_valid_o);
                end
                exp_pc = {tgt[31:2], 2'b00};
            end else if (fbus.fetch_valid_o === 1'b1 && fbus.fetch_ready_i) begin
                n_cmp++;
                if (fbus.fetch_pc_o !== exp_pc || fbus.fetch_instr_o !== instr_at(exp_pc)) begin
                    n_err++; $display("FAIL rand_stream i%0d: got pc %h instr %h want pc %h instr %h",
                                      i, fbus.fetch_pc_o, fbus.fetch_instr_o, exp_pc, instr_at(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
            end
            step();
        end
        fbus.redirect_valid_i = 1'b0;
        fbus.fetch_ready_i    = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k >= 4) begin
                n_cmp++;
                if (fbus.fetch_valid_o !== 1'b1) begin
                    n_err++; $display("FAIL throughput k%0d: got valid %0b want 1", k, fbus.fetch_valid_o);
                end
            end
            if (fbus.fetch_valid_o === 1'b1) begin
                n_cmp++;
                if (fbus.fetch_pc_o !== exp_pc) begin
                    n_err++; $display("FAIL throughput_pc k%0d: got %h want %h", k, fbus.fetch_pc_o, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
            end
            step();
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset(1'b0);
        step(); step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        fbus.fetch_ready_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (c < 3) begin
                if (fbus.fetch_valid_o !== 1'b0) begin
                    n_err++; $display("FAIL midreset_valid C%0d: got %0b want 0", c, fbus.fetch_valid_o);
                end
            end else if (fbus.fetch_valid_o !== 1'b1 || fbus.fetch_pc_o !== 32'(4 * (c - 3))) begin
                n_err++; $display("FAIL midreset_restart C%0d: got v%0b pc %h want v1 pc %h",
                                  c, fbus.fetch_valid_o, fbus.fetch_pc_o, 32'(4 * (c - 3)));
            end
            step();
        end
    endtask

    task automatic test_misalign();
        logic got;
        logic [31:0] e_pc;
        apply_reset(1'b1);
        step(); step(); step();
        fbus.redirect_valid_i = 1'b1;
        fbus.redirect_pc_i    = 32'h42;
        @(negedge clk);
        n_cmp++;
        if (fbus.fetch_valid_o !== 1'b0) begin
            n_err++; $display("FAIL mis_redir_valid: got %0b want 0", fbus.fetch_valid_o);
        end
        step();
        fbus.redirect_valid_i = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if (fbus.fetch_misaligned_o !== (k == 0) || fbus.fetch_valid_o !== 1'b0) begin
                n_err++; $display("FAIL mis_halt k%0d: got mis %0b valid %0b want mis %0b valid 0",
                                  k, fbus.fetch_misaligned_o, fbus.fetch_valid_o, (k == 0));
            end
            step();
        end
        fbus.redirect_valid_i = 1'b1;
        fbus.redirect_pc_i    = 32'h80;
        step();
        fbus.redirect_valid_i = 1'b0;
        e_pc = 32'h80;
`else
        e_pc = 32'h40;
`endif
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge clk);
            if (fbus.fetch_valid_o) begin
                got = 1'b1;
                n_cmp++;
                if (fbus.fetch_pc_o !== e_pc || fbus.fetch_instr_o !== instr_at(e_pc)) begin
                    n_err++; $display("FAIL mis_resume: got pc %h instr %h want pc %h instr %h",
                                      fbus.fetch_pc_o, fbus.fetch_instr_o, e_pc, instr_at(e_pc));
                end
            end
            step();
        end
        if (!got) begin
            n_cmp++; n_err++; $display("FAIL mis_timeout: got no valid want pc %h", e_pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h0123_4567;
        mem[1] = 32'h89AB_CDEF;
        fbus.redirect_valid_i = 1'b0;
        fbus.redirect_pc_i    = 32'h0;
        fbus.fetch_ready_i    = 1'b1;
        wbus.redirect_valid_i = 1'b0;
        wbus.redirect_pc_i    = 32'h0;
        wbus.fetch_ready_i    = 1'b1;
        test_reset();
        test_boot_and_wrap();
        test_backpressure();
        test_redirect();
        test_random();
        test_reset_midstream();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
